// File: rtl/cav_lock_supervisor_pkg.sv
// Shared widths, FSM state codes and helpers for the cavity lock supervisor.
package cav_lock_supervisor_pkg;

  localparam int FILTER_IO_SIZE_DEF = 25;
  localparam int CNT_W_DEF          = 24;
  localparam int RELOCK_W_DEF       = 8;
  localparam int ST_W               = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_CATCH  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_RELOCK = 3'd4
  } state_e;

  // The servo runs only while catching or holding lock.
  function automatic logic pid_active(input state_e s);
    return (s == ST_CATCH) || (s == ST_LOCKED);
  endfunction

endpackage

// File: rtl/cav_lock_supervisor_if.sv
// Control/status bundle between the lock supervisor (slv) and its host/servo side (mst).
interface cav_lock_supervisor_if
  import cav_lock_supervisor_pkg::*;
#(
  parameter int FILTER_IO_SIZE = FILTER_IO_SIZE_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int RELOCK_W       = RELOCK_W_DEF
);
  logic                             en;
  logic signed [FILTER_IO_SIZE-1:0] trans;
  logic signed [FILTER_IO_SIZE-1:0] trans_thr;
  logic signed [FILTER_IO_SIZE-1:0] s_out;
  logic signed [FILTER_IO_SIZE-1:0] LL;
  logic signed [FILTER_IO_SIZE-1:0] UL;
  logic        [FILTER_IO_SIZE-1:0] scan_step;
  logic        [CNT_W-1:0]          settle_cyc;
  logic        [CNT_W-1:0]          lost_cyc;
  logic                             pid_on;
  logic                             pid_hld;
  logic signed [FILTER_IO_SIZE-1:0] scan_out;
  logic        [ST_W-1:0]           state;
  logic                             locked;
  logic        [RELOCK_W-1:0]       relock_cnt;

  modport slv (
    input  en, trans, trans_thr, s_out, LL, UL, scan_step, settle_cyc, lost_cyc,
    output pid_on, pid_hld, scan_out, state, locked, relock_cnt
  );

  modport mst (
    output en, trans, trans_thr, s_out, LL, UL, scan_step, settle_cyc, lost_cyc,
    input  pid_on, pid_hld, scan_out, state, locked, relock_cnt
  );

endinterface

// File: rtl/cav_lock_timer.sv
// Saturating up-counter with synchronous clear; tc_o marks the last cycle of a term_i-long window.
// A term_i of zero behaves as one so the window is never empty.
module cav_lock_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign last = (term_i == '0) ? '0 : term_i - CNT_W'(1);
  assign tc_o = (cnt_q == last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cav_lock_supervisor.sv
// Cavity lock supervisor: scan -> catch -> locked -> relock FSM driving the PID servo on/hold inputs.
// Define CAV_LOCK_DROPOUT_HOLD_EN to freeze the servo integrator (pid_hld) during dropouts while locked.
module cav_lock_supervisor
  import cav_lock_supervisor_pkg::*;
#(
  parameter int FILTER_IO_SIZE = FILTER_IO_SIZE_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int RELOCK_W       = RELOCK_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  cav_lock_supervisor_if.slv bus
);
  localparam int W = FILTER_IO_SIZE;

  state_e              state_q, state_d;
  logic signed [W-1:0] scan_q, scan_d;
  logic                dir_dn_q, dir_dn_d;
  logic                pid_on_q, locked_q;
  logic [RELOCK_W-1:0] relock_q;
  logic                trans_hi, bad;
  logic                settle_clr, settle_tc, bad_clr, bad_tc;
  logic signed [W:0]   scan_w, step_w, ul_w, ll_w, sum_w;

  assign trans_hi = bus.trans >= bus.trans_thr;
  assign bad      = !trans_hi || (bus.s_out >= bus.UL) || (bus.s_out <= bus.LL);

  // Each timer runs only across an unbroken streak of its qualifying condition.
  assign settle_clr = !(bus.en && (state_q == ST_CATCH) && trans_hi);
  assign bad_clr    = !(bus.en && (state_q == ST_LOCKED) && bad);

  cav_lock_timer #(.CNT_W(CNT_W)) u_settle_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (settle_clr),
    .inc_i  (1'b1),
    .term_i (bus.settle_cyc),
    .tc_o   (settle_tc)
  );

  cav_lock_timer #(.CNT_W(CNT_W)) u_bad_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (bad_clr),
    .inc_i  (1'b1),
    .term_i (bus.lost_cyc),
    .tc_o   (bad_tc)
  );

  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_SCAN;
        ST_SCAN:   if (trans_hi) state_d = ST_CATCH;
        ST_CATCH:  if (!trans_hi) state_d = ST_SCAN;
                   else if (settle_tc) state_d = ST_LOCKED;
        ST_LOCKED: if (bad && bad_tc) state_d = ST_RELOCK;
        ST_RELOCK: state_d = ST_SCAN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // One extra bit keeps the ramp sum from wrapping before it is clamped.
  assign scan_w = {scan_q[W-1], scan_q};
  assign step_w = {1'b0, bus.scan_step};
  assign ul_w   = {bus.UL[W-1], bus.UL};
  assign ll_w   = {bus.LL[W-1], bus.LL};
  assign sum_w  = dir_dn_q ? (scan_w - step_w) : (scan_w + step_w);

  always_comb begin
    scan_d   = scan_q;
    dir_dn_d = dir_dn_q;
    if ((state_q == ST_SCAN) && (state_d == ST_SCAN)) begin
      if (sum_w >= ul_w) begin
        scan_d   = bus.UL;
        dir_dn_d = 1'b1;
      end else if (sum_w <= ll_w) begin
        scan_d   = bus.LL;
        dir_dn_d = 1'b0;
      end else begin
        scan_d = sum_w[W-1:0];
      end
    end
    if (state_d == ST_IDLE) dir_dn_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      scan_q   <= '0;
      dir_dn_q <= 1'b0;
      pid_on_q <= 1'b0;
      locked_q <= 1'b0;
      relock_q <= '0;
    end else begin
      state_q  <= state_d;
      scan_q   <= scan_d;
      dir_dn_q <= dir_dn_d;
      pid_on_q <= pid_active(state_d);
      locked_q <= (state_d == ST_LOCKED);
      if ((state_q == ST_LOCKED) && (state_d == ST_RELOCK) && !(&relock_q)) begin
        relock_q <= relock_q + RELOCK_W'(1);
      end
    end
  end

`ifdef CAV_LOCK_DROPOUT_HOLD_EN
  logic pid_hld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pid_hld_q <= 1'b0;
    end else begin
      pid_hld_q <= (state_q == ST_LOCKED) && (state_d == ST_LOCKED) && !trans_hi;
    end
  end

  assign bus.pid_hld = pid_hld_q;
`else
  assign bus.pid_hld = 1'b0;
`endif

  assign bus.pid_on     = pid_on_q;
  assign bus.scan_out   = scan_q;
  assign bus.state      = state_q;
  assign bus.locked     = locked_q;
  assign bus.relock_cnt = relock_q;

endmodule

// File: tb/tb_cav_lock_supervisor.sv
// Directed bench for cav_lock_supervisor: spec-level reference model compared every cycle plus hand-computed checkpoints.
module tb_cav_lock_supervisor;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   v_trans, v_thr, v_sout, v_ll, v_ul, v_step, v_settle, v_lost;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  cav_lock_supervisor_if ifc ();

  assign ifc.en         = en;
  assign ifc.trans      = v_trans[24:0];
  assign ifc.trans_thr  = v_thr[24:0];
  assign ifc.s_out      = v_sout[24:0];
  assign ifc.LL         = v_ll[24:0];
  assign ifc.UL         = v_ul[24:0];
  assign ifc.scan_step  = v_step[24:0];
  assign ifc.settle_cyc = v_settle[23:0];
  assign ifc.lost_cyc   = v_lost[23:0];

  cav_lock_supervisor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slv)
  );

  // Reference: st 0..4 = idle/scan/catch/locked/relock; streak counters count whole cycles.
  typedef struct {
    int st;
    int scan;
    int dir;
    int catchn;
    int badn;
    int relock;
    bit hld;
  } mdl_t;

  mdl_t m = '{st: 0, scan: 0, dir: 1, catchn: 0, badn: 0, relock: 0, hld: 1'b0};

  function automatic mdl_t model_step(input mdl_t c);
    mdl_t n = c;
    bit   hi = (v_trans >= v_thr);
    bit   bd = !hi || (v_sout >= v_ul) || (v_sout <= v_ll);
    int   need_settle = (v_settle == 0) ? 1 : v_settle;
    int   need_lost   = (v_lost == 0) ? 1 : v_lost;
    n.hld = 1'b0;
    if (!rst_n) begin
      n = '{st: 0, scan: 0, dir: 1, catchn: 0, badn: 0, relock: 0, hld: 1'b0};
    end else if (!en) begin
      n.st = 0; n.dir = 1; n.catchn = 0; n.badn = 0;
    end else begin
      case (c.st)
        0: n.st = 1;
        1: begin
          if (hi) n.st = 2;
          else begin
            n.scan = c.scan + c.dir * v_step;
            if (n.scan >= v_ul) begin n.scan = v_ul; n.dir = -1; end
            else if (n.scan <= v_ll) begin n.scan = v_ll; n.dir = 1; end
          end
        end
        2: begin
          if (!hi) begin n.st = 1; n.catchn = 0; end
          else begin
            n.catchn = c.catchn + 1;
            if (n.catchn >= need_settle) begin n.st = 3; n.catchn = 0; end
          end
        end
        3: begin
          n.badn = bd ? c.badn + 1 : 0;
          if (n.badn >= need_lost) begin
            n.st = 4; n.badn = 0;
            if (c.relock < 255) n.relock = c.relock + 1;
          end
`ifdef CAV_LOCK_DROPOUT_HOLD_EN
          if (n.st == 3 && !hi) n.hld = 1'b1;
`endif
        end
        default: n.st = 1;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, $signed(act), $signed(exp), $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_state",  32'(ifc.state),      32'(m.st));
      chk("model_scan",   32'(ifc.scan_out),   32'(m.scan));
      chk("model_pid_on", 32'(ifc.pid_on),     (m.st == 2 || m.st == 3) ? 32'd1 : 32'd0);
      chk("model_locked", 32'(ifc.locked),     (m.st == 3) ? 32'd1 : 32'd0);
      chk("model_relock", 32'(ifc.relock_cnt), 32'(m.relock));
      chk("model_hld",    32'(ifc.pid_hld),    32'(m.hld));
    end
  end

  task automatic wait_scan(input int val, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ifc.state == 3'd1 && 32'(ifc.scan_out) == 32'(val)) && n < budget);
    chk("wait_scan", 32'(ifc.scan_out), 32'(val));
  endtask

  task automatic chk_reset_outputs(input string nm, input int exp_relock);
    chk({nm, "_state"},  32'(ifc.state),      32'd0);
    chk({nm, "_pid_on"}, 32'(ifc.pid_on),     32'd0);
    chk({nm, "_locked"}, 32'(ifc.locked),     32'd0);
    chk({nm, "_hld"},    32'(ifc.pid_hld),    32'd0);
    chk({nm, "_relock"}, 32'(ifc.relock_cnt), 32'(exp_relock));
  endtask

  int wrap_exp [13] = '{0, 30, 60, 90, 100, 70, 40, 10, -20, -50, -80, -100, -70};

  initial begin
    rst_n = 1'b0; en = 1'b0;
    v_ll = -100; v_ul = 100; v_step = 30; v_trans = 0; v_thr = 400;
    v_sout = 0; v_settle = 10; v_lost = 8;
    @(negedge clk);
    chk_en = 1'b1;
    chk_reset_outputs("reset", 0);
    chk("reset_scan", 32'(ifc.scan_out), 32'd0);

    // Scan ramp with clamping and direction reversal at both limits.
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("scan_wrap", 32'(ifc.scan_out), 32'(wrap_exp[i]));
    end
    en = 1'b0;
    @(negedge clk);
    chk("idle_state", 32'(ifc.state), 32'd0);
    chk("idle_scan_held", 32'(ifc.scan_out), -32'sd70);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_scan", 32'(ifc.scan_out), 32'd0);
    rst_n = 1'b1; en = 1'b1;

    // Catch at 60, abort on 5th catch cycle, scan resumes upward from 60.
    wait_scan(60, 10);
    v_trans = 500;
    repeat (5) @(negedge clk);
    chk("catch_state", 32'(ifc.state), 32'd2);
    chk("catch_pid_on", 32'(ifc.pid_on), 32'd1);
    chk("catch_scan_frozen", 32'(ifc.scan_out), 32'd60);
    v_trans = 0;
    @(negedge clk);
    chk("abort_state", 32'(ifc.state), 32'd1);
    chk("abort_scan", 32'(ifc.scan_out), 32'd60);
    @(negedge clk);
    chk("abort_resume", 32'(ifc.scan_out), 32'd90);

    // Full settle: 10 cycles of CATCH, then LOCKED.
    v_trans = 500;
    repeat (10) @(negedge clk);
    chk("settle_last_catch", 32'(ifc.state), 32'd2);
    chk("settle_not_locked", 32'(ifc.locked), 32'd0);
    @(negedge clk);
    chk("lock_state", 32'(ifc.state), 32'd3);
    chk("lock_locked", 32'(ifc.locked), 32'd1);
    chk("lock_scan", 32'(ifc.scan_out), 32'd90);

    // Seven-cycle dropout stays below lost_cyc=8.
    v_trans = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
`ifdef CAV_LOCK_DROPOUT_HOLD_EN
      chk("glitch_hld", 32'(ifc.pid_hld), 32'd1);
`else
      chk("glitch_hld", 32'(ifc.pid_hld), 32'd0);
`endif
    end
    v_trans = 500;
    @(negedge clk);
    chk("glitch_still_locked", 32'(ifc.state), 32'd3);
    chk("glitch_hld_clear", 32'(ifc.pid_hld), 32'd0);

    // PID railed at UL for 8 cycles -> one RELOCK cycle -> SCAN.
    v_sout = 100;
    repeat (7) @(negedge clk);
    chk("rail_pre_state", 32'(ifc.state), 32'd3);
    @(negedge clk);
    chk("relock_state", 32'(ifc.state), 32'd4);
    chk("relock_pid_on", 32'(ifc.pid_on), 32'd0);
    chk("relock_cnt", 32'(ifc.relock_cnt), 32'd1);
    v_sout = 0;
    @(negedge clk);
    chk("relock_to_scan", 32'(ifc.state), 32'd1);
    @(negedge clk);
    chk("recatch", 32'(ifc.state), 32'd2);

    // en drop mid-CATCH keeps relock_cnt.
    en = 1'b0;
    @(negedge clk);
    chk_reset_outputs("en_drop", 1);

    // settle_cyc=0 behaves as a single CATCH cycle.
    en = 1'b1; v_settle = 0;
    repeat (3) @(negedge clk);
    chk("settle0_locked", 32'(ifc.state), 32'd3);

    // Reset mid-CATCH clears everything, including relock_cnt.
    v_settle = 10; en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_catch", 32'(ifc.state), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_catch", 0);
    chk("rst_catch_scan", 32'(ifc.scan_out), 32'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
